// File: rtl/csel_sub_8b_pipe.sv
// ---------------------------------------------------------------------------
// csel_sub_8b_pipe
//   Two-stage pipelined carry-select subtractor: d = a - b - bin (mod 2^WIDTH),
//   with borrow-out and signed-overflow flags.
//   Stage 1 registers the low-half difference with its borrow, and both
//   high-half candidates (borrow-in 0 and 1). Stage 2 picks the high half
//   using the low-half borrow. valid/ready on both sides with full
//   backpressure; at most two operations are in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a, b       minuend / subtrahend (WIDTH bits)
//   bin        borrow-in
//   in_valid   operands valid
//   in_ready   unit can accept operands this cycle (combinational)
//   d          registered difference
//   bout       registered borrow-out (1 iff unsigned a < b + bin)
//   ovf        registered signed overflow
//   out_valid  d/bout/ovf valid
//   out_ready  downstream accepts the result
// ---------------------------------------------------------------------------
module csel_sub_8b_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned HW  = WIDTH / 2;
    localparam int unsigned HW1 = HW + 1;
    localparam int unsigned MSB = WIDTH - 1;

    // Stage 1 state
    logic          s1_valid_q, s1_valid_d;
    logic [HW-1:0] lo_q, lo_d;
    logic          bl_q, bl_d;
    logic [HW-1:0] h0_q, h0_d;
    logic          h0b_q, h0b_d;
    logic [HW-1:0] h1_q, h1_d;
    logic          h1b_q, h1b_d;
    logic          am_q, am_d;
    logic          bm_q, bm_d;

    // Stage 2 (output) state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic           s2_adv;
    logic           accept;
    logic           consume;
    logic [HW1-1:0] lo_full;
    logic [HW1-1:0] h0_full;
    logic [HW1-1:0] h1_full;
    logic [HW-1:0]  hsel;
    logic           hsel_b;
    logic [WIDTH-1:0] dsel;

    // Handshake and stall logic
    always_comb begin
        s2_adv   = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !rst && (!s1_valid_q || s2_adv);
        accept   = in_valid && in_ready;
        consume  = out_valid_q && out_ready;
    end

    // Stage 1 datapath: one extra bit on each half captures its borrow
    always_comb begin
        lo_full = {1'b0, a[HW-1:0]} - {1'b0, b[HW-1:0]} - HW1'(bin);
        h0_full = {1'b0, a[MSB:HW]} - {1'b0, b[MSB:HW]};
        h1_full = {1'b0, a[MSB:HW]} - {1'b0, b[MSB:HW]} - HW1'(1'b1);
    end

    // Stage 1 next state: load on accept, drain when stage 2 takes the op
    always_comb begin
        s1_valid_d = s1_valid_q;
        lo_d       = lo_q;
        bl_d       = bl_q;
        h0_d       = h0_q;
        h0b_d      = h0b_q;
        h1_d       = h1_q;
        h1b_d      = h1b_q;
        am_d       = am_q;
        bm_d       = bm_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            lo_d       = lo_full[HW-1:0];
            bl_d       = lo_full[HW];
            h0_d       = h0_full[HW-1:0];
            h0b_d      = h0_full[HW];
            h1_d       = h1_full[HW-1:0];
            h1b_d      = h1_full[HW];
            am_d       = a[MSB];
            bm_d       = b[MSB];
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 2 select: low-half borrow chooses the high candidate
    always_comb begin
        hsel   = bl_q ? h1_q  : h0_q;
        hsel_b = bl_q ? h1b_q : h0b_q;
        dsel   = {hsel, lo_q};
    end

    // Stage 2 next state: load on advance, otherwise hold (stable under stall)
    always_comb begin
        out_valid_d = out_valid_q;
        d_d         = d_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        if (s2_adv) begin
            out_valid_d = 1'b1;
            d_d         = dsel;
            bout_d      = hsel_b;
            ovf_d       = (am_q != bm_q) && (dsel[MSB] != am_q);
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            lo_q        <= '0;
            bl_q        <= 1'b0;
            h0_q        <= '0;
            h0b_q       <= 1'b0;
            h1_q        <= '0;
            h1b_q       <= 1'b0;
            am_q        <= 1'b0;
            bm_q        <= 1'b0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_q        <= lo_d;
            bl_q        <= bl_d;
            h0_q        <= h0_d;
            h0b_q       <= h0b_d;
            h1_q        <= h1_d;
            h1b_q       <= h1b_d;
            am_q        <= am_d;
            bm_q        <= bm_d;
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_csel_sub_8b_pipe.sv
// ---------------------------------------------------------------------------
// tb_csel_sub_8b_pipe
//   Self-checking bench for csel_sub_8b_pipe. Expected results come from a
//   plain-arithmetic reference and an in-order queue of accepted operations.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_csel_sub_8b_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    // {ovf, bout, d} for each accepted, not yet consumed operation
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    csel_sub_8b_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: integer subtraction, borrow = negative result
    function automatic logic [9:0] ref_sub(input logic [7:0] ra, input logic [7:0] rb,
                                           input logic rbin);
        int         diff;
        logic [7:0] rd;
        logic       rbo, rov;
        diff = int'(ra) - int'(rb) - int'(rbin);
        rd   = 8'(diff);
        rbo  = (diff < 0);
        rov  = (ra[7] != rb[7]) && (rd[7] != ra[7]);
        return {rov, rbo, rd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if ({ovf, bout, d} !== 10'h000) begin n_fail++; $display("FAIL reset_outputs got %h want 000", {ovf, bout, d}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_directed();
        // a, b, bin, expected {ovf, bout, d}
        logic [7:0] va[8]  = '{8'h05, 8'h00, 8'hFF, 8'h10, 8'h80, 8'hA5, 8'hAA, 8'h00};
        logic [7:0] vb[8]  = '{8'h03, 8'h01, 8'hFF, 8'h01, 8'h01, 8'h5A, 8'h55, 8'h00};
        logic       vc[8]  = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        logic [9:0] ve[8]  = '{10'h002, 10'h1FF, 10'h1FF, 10'h00F, 10'h27F, 10'h24A, 10'h255, 10'h1FF};
        for (int i = 0; i < 8; i++) begin
            a = va[i]; b = vb[i]; bin = vc[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready got %b want 1", i, in_ready); end
            tick();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid got %b want 0", i, out_valid); end
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency got %b want 1", i, out_valid); end
            n_cmp++; if ({ovf, bout, d} !== ve[i]) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, {ovf, bout, d}, ve[i]); end
            n_cmp++; if (ref_sub(va[i], vb[i], vc[i]) !== ve[i]) begin n_fail++; $display("FAIL dir%0d_refmodel got %h want %h", i, ref_sub(va[i], vb[i], vc[i]), ve[i]); end
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_dup got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] oa[4], ob[4];
        logic       oc[4];
        logic [9:0] held, got;
        logic       held_ok;
        int         acc, popped;
        for (int i = 0; i < 4; i++) begin
            oa[i] = 8'($urandom); ob[i] = 8'($urandom); oc[i] = 1'($urandom);
        end
        exp_q.delete();
        acc = 0; popped = 0; held_ok = 1'b0; held = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) begin
                if (held_ok) begin
                    n_cmp++; if ({ovf, bout, d} !== held) begin n_fail++; $display("FAIL bp_stable got %h want %h", {ovf, bout, d}, held); end
                end else begin
                    held = {ovf, bout, d}; held_ok = 1'b1;
                    n_cmp++; if (held !== exp_q[0]) begin n_fail++; $display("FAIL bp_head got %h want %h", held, exp_q[0]); end
                end
            end
            in_valid = 1'b1; a = oa[acc]; b = ob[acc]; bin = oc[acc];
            #1;
            if (in_ready) begin exp_q.push_back(ref_sub(oa[acc], ob[acc], oc[acc])); acc++; end
            tick();
        end
        n_cmp++; if (acc !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", acc); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_cmp++; if (!held_ok || {ovf, bout, d} !== held) begin n_fail++; $display("FAIL bp_hold got %h want %h", {ovf, bout, d}, held); end
        out_ready = 1'b1;
        for (int c = 0; c < 30 && popped < 4; c++) begin
            in_valid = (acc < 4);
            if (acc < 4) begin a = oa[acc]; b = ob[acc]; bin = oc[acc]; end
            #1;
            if (out_valid && out_ready) begin
                got = {ovf, bout, d};
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra got %h want none", got); end
                else begin
                    if (got !== exp_q[0]) begin n_fail++; $display("FAIL bp_order%0d got %h want %h", popped, got, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                popped++;
            end
            if (in_valid && in_ready) begin exp_q.push_back(ref_sub(oa[acc], ob[acc], oc[acc])); acc++; end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (popped !== 4 || acc !== 4) begin n_fail++; $display("FAIL bp_drain got %0d/%0d want 4/4", popped, acc); end
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", out_valid); end
    endtask

    task automatic test_random_stream();
        logic [9:0] got, held;
        logic       hold_prev, exp_rdy;
        exp_q.delete();
        hold_prev = 1'b0; held = '0;
        for (int c = 0; c < 400; c++) begin
            if (hold_prev) begin
                n_cmp++; if (out_valid !== 1'b1 || {ovf, bout, d} !== held) begin n_fail++; $display("FAIL rnd_stall%0d got %b/%h want 1/%h", c, out_valid, {ovf, bout, d}, held); end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = (exp_q.size() < 2) ? 1'b1 : out_ready;
            n_cmp++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready%0d got %b want %b", c, in_ready, exp_rdy); end
            if (out_valid && out_ready) begin
                got = {ovf, bout, d};
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_phantom%0d got %h want none", c, got); end
                else begin
                    if (got !== exp_q[0]) begin n_fail++; $display("FAIL rnd_result%0d got %h want %h", c, got, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b, bin));
            hold_prev = out_valid && !out_ready;
            held      = {ovf, bout, d};
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                got = {ovf, bout, d};
                n_cmp++; if (got !== exp_q[0]) begin n_fail++; $display("FAIL rnd_drain got %h want %h", got, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_lost got %0d left want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [9:0] want;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_accept%0d got %b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_ready got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || d !== 8'h00) begin n_fail++; $display("FAIL rm_flush got %b/%h want 0/00", out_valid, d); end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stale%0d got %b want 0", c, out_valid); end
        end
        in_valid = 1'b1; a = 8'h37; b = 8'h5C; bin = 1'b1;
        want = ref_sub(8'h37, 8'h5C, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || {ovf, bout, d} !== want) begin n_fail++; $display("FAIL rm_new got %b/%h want 1/%h", out_valid, {ovf, bout, d}, want); end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
